bitgrid_loader: RTL and testbench

//  - Producer side of the 2-D bit-array input used by our array-consuming blocks
//    (e.g. a 4x4 'input reg x [3:0][0:3]' port).
//  - Collects a serial, even-parity-protected bitstream into a ROWSxCOLS unpacked grid.
//  - Presents the completed grid with a valid/ready handshake; corrupted frames are dropped.
//  - Sits between a serial stimulus/config source and any module taking an unpacked bit matrix.

---
 rtl/bitgrid_loader.sv | 129 ++++++++++++
 tb/tb_bitgrid_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitgrid_loader.sv
// Serial even-parity bitstream -> ROWSxCOLS unpacked bit grid with valid/ready output.
// Grid and m_valid update one edge after the good parity bit; s_ready drops only while a frame is held.
module bitgrid_loader #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_bit,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            grid [ROWS-1:0][0:COLS-1],
    output logic            perr,
    output logic [CNTW-1:0] frame_cnt,
    output logic [CNTW-1:0] perr_cnt
);

    localparam int N    = ROWS * COLS;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAR  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDXW-1:0] r_idx;
    logic            r_par;
    logic [N-1:0]    r_buf;
    logic            r_m_valid;
    logic            r_perr;
    logic [CNTW-1:0] r_frame_cnt;
    logic [CNTW-1:0] r_perr_cnt;
    logic            r_grid [ROWS-1:0][0:COLS-1];

    logic w_xfer;
    logic w_par_xfer;
    logic w_good;
    logic w_bad;

    assign s_ready    = (r_state != HOLD);
    assign w_xfer     = s_valid && s_ready;
    assign w_par_xfer = (r_state == PAR) && w_xfer;
    assign w_good     = w_par_xfer && !(r_par ^ s_bit);
    assign w_bad      = w_par_xfer &&  (r_par ^ s_bit);

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    if (w_xfer && (r_idx == LAST_IDX)) w_next = PAR;
            PAR:     if (w_xfer) w_next = w_good ? HOLD : FILL;
            HOLD:    if (m_ready) w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // r_buf bit k holds data bit k in arrival order; the grid mapping is applied on copy-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_par <= 1'b0;
            r_buf <= '0;
        end else begin
            if ((r_state == FILL) && w_xfer) begin
                r_buf[r_idx] <= s_bit;
                r_par        <= r_par ^ s_bit;
                r_idx        <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end else if (w_par_xfer || ((r_state == HOLD) && m_ready)) begin
                r_idx <= '0;
                r_par <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid   <= 1'b0;
            r_perr      <= 1'b0;
            r_frame_cnt <= '0;
            r_perr_cnt  <= '0;
        end else begin
            r_perr <= w_bad;
            if (w_good) begin
                r_m_valid   <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end else if ((r_state == HOLD) && m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_bad && (r_perr_cnt != {CNTW{1'b1}})) begin
                r_perr_cnt <= r_perr_cnt + 1'b1;
            end
        end
    end

    // Data bit k lands in row ROWS-1-k/COLS, column k%COLS.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K = (ROWS - 1 - r) * COLS + c;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_grid[r][c] <= 1'b0;
                end else if (w_good) begin
                    r_grid[r][c] <= r_buf[K];
                end
            end
            assign grid[r][c] = r_grid[r][c];
        end
    end

    assign m_valid   = r_m_valid;
    assign perr      = r_perr;
    assign frame_cnt = r_frame_cnt;
    assign perr_cnt  = r_perr_cnt;

endmodule

// File: tb/tb_bitgrid_loader.sv
// Directed bench for bitgrid_loader (4x4, CNTW=8): framing, parity drop, stalls, reset, counters, streaming.
module tb_bitgrid_loader;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic       s_bit;
    logic       m_valid;
    logic       m_ready;
    logic       grid [3:0][0:3];
    logic       perr;
    logic [7:0] frame_cnt;
    logic [7:0] perr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bitgrid_loader #(.ROWS(4), .COLS(4), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_bit     (s_bit),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .grid      (grid),
        .perr      (perr),
        .frame_cnt (frame_cnt),
        .perr_cnt  (perr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flattened grid in arrival order: bit 15 is the first data bit sent.
    function automatic logic [15:0] gflat();
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[15-k] = grid[3 - k/4][k%4];
        return v;
    endfunction

    function automatic logic [3:0] grow(input int r);
        return {grid[r][0], grid[r][1], grid[r][2], grid[r][3]};
    endfunction

    task automatic send_bit(input logic b);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_bit   = b;
        while (!s_ready && w < 50) begin
            tick();
            w++;
        end
        if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_data(input logic [15:0] d, input bit gaps);
        for (int k = 0; k < 16; k++) begin
            send_bit(d[15-k]);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic release_hold();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    logic        bits [$];
    logic [15:0] t6_dat [3];
    int          pos;
    int          seen;
    int          last_cyc;
    logic        xfer;

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        m_ready = 1'b0;
        repeat (2) tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_perr", 32'(perr), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_perr_cnt", 32'(perr_cnt), 32'd0);
        check("rst_grid", 32'(gflat()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_s_ready", 32'(s_ready), 32'd1);

        // T1: 0xA5C3, parity 0
        send_data(16'hA5C3, 1'b0);
        check("t1_no_valid_before_par", 32'(m_valid), 32'd0);
        send_bit(1'b0);
        check("t1_m_valid", 32'(m_valid), 32'd1);
        check("t1_grid", 32'(gflat()), 32'hA5C3);
        check("t1_row3", 32'(grow(3)), 32'hA);
        check("t1_row0", 32'(grow(0)), 32'h3);
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_s_ready_hold", 32'(s_ready), 32'd0);
        release_hold();
        check("t1_m_valid_drop", 32'(m_valid), 32'd0);
        check("t1_s_ready_back", 32'(s_ready), 32'd1);

        // T2: bad parity then a good frame
        send_data(16'hFFFF, 1'b0);
        send_bit(1'b1);
        check("t2_perr_pulse", 32'(perr), 32'd1);
        check("t2_perr_cnt", 32'(perr_cnt), 32'd1);
        check("t2_m_valid", 32'(m_valid), 32'd0);
        check("t2_grid_kept", 32'(gflat()), 32'hA5C3);
        tick();
        check("t2_perr_end", 32'(perr), 32'd0);
        send_data(16'h1234, 1'b0);
        send_bit(1'b1);
        check("t2_good_valid", 32'(m_valid), 32'd1);
        check("t2_good_grid", 32'(gflat()), 32'h1234);
        check("t2_frame_cnt", 32'(frame_cnt), 32'd2);
        release_hold();

        // T3: gaps inside frame, then 10 stalled cycles with s_valid asserted
        send_data(16'h5A0F, 1'b1);
        send_bit(1'b0);
        check("t3_valid", 32'(m_valid), 32'd1);
        s_valid = 1'b1;
        s_bit   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_stall_s_ready", 32'(s_ready), 32'd0);
            check("t3_stall_grid", 32'(gflat()), 32'h5A0F);
        end
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("t3_frame_cnt", 32'(frame_cnt), 32'd3);
        check("t3_grid_after", 32'(gflat()), 32'h5A0F);

        // T4: async reset after 9 bits
        for (int k = 0; k < 9; k++) send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        check("t4_grid", 32'(gflat()), 32'd0);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t4_perr_cnt", 32'(perr_cnt), 32'd0);
        check("t4_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t4_perr", 32'(perr), 32'd0);
        check("t4_s_ready", 32'(s_ready), 32'd1);
        send_data(16'h0F0F, 1'b0);
        send_bit(1'b0);
        check("t4_new_grid", 32'(gflat()), 32'h0F0F);
        check("t4_new_cnt", 32'(frame_cnt), 32'd1);
        release_hold();

        // T5: counter wrap and saturation
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] d;
            d = 16'(i * 37 + 5);
            send_data(d, 1'b0);
            send_bit(^d);
            if (i == 254) check("t5_frame_cnt_255", 32'(frame_cnt), 32'd255);
        end
        check("t5_frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        for (int i = 0; i < 300; i++) begin
            logic [15:0] d;
            d = 16'(i * 91 + 3);
            send_data(d, 1'b0);
            send_bit(~(^d));
            if (i == 254) check("t5_perr_cnt_255", 32'(perr_cnt), 32'd255);
        end
        check("t5_perr_cnt_sat", 32'(perr_cnt), 32'd255);
        check("t5_frame_cnt_kept", 32'(frame_cnt), 32'd0);

        // T6: back-to-back stream, m_ready tied high
        t6_dat[0] = 16'h8001;
        t6_dat[1] = 16'h7FFE;
        t6_dat[2] = 16'hC3A5;
        for (int f = 0; f < 3; f++) begin
            logic [15:0] d;
            d = t6_dat[f];
            for (int k = 0; k < 16; k++) bits.push_back(d[15-k]);
            bits.push_back(^d);
        end
        pos      = 0;
        seen     = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 200 && seen < 3; cyc++) begin
            s_valid = (pos < bits.size());
            s_bit   = s_valid ? bits[pos] : 1'b0;
            xfer    = s_valid && s_ready;
            tick();
            if (xfer) pos++;
            if (m_valid) begin
                check("t6_grid", 32'(gflat()), 32'(t6_dat[seen]));
                if (last_cyc >= 0) check("t6_spacing", 32'(cyc - last_cyc), 32'd18);
                last_cyc = cyc;
                seen++;
            end
        end
        s_valid = 1'b0;
        check("t6_frames", 32'(seen), 32'd3);
        check("t6_bits_used", 32'(pos), 32'd51);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
